rv32i_regfile: RTL and testbench
================================

# rv32i_regfile

Integer register file of the RV32I core: 32 × 32-bit registers with two synchronous read ports (rs1, rs2) and one write port driven by the write-back data mux. Read outputs are registered, giving one-cycle read latency, and feed the execute stage. The read outputs can be frozen under pipeline stall. x0 is hardwired to zero.

## Interface
- `XLEN`, 32: register data width.
- `NREG`, 32: number of architectural registers. Address width is fixed at 5.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  1 = hold rs1_data/rs2_data at current values.
- `rs1_addr`  in  5  read port 1 address, sampled at clock edge when stall=0.
- `rs2_addr`  in  5  read port 2 address, sampled at clock edge when stall=0.
- `rd_we`  in  1  write enable from write-back stage.
- `rd_addr`  in  5  write address.
- `rd_data`  in  XLEN  write data (output of write-back mux).
- `rs1_data`  out  XLEN  registered read data, port 1.
- `rs2_data`  out  XLEN  registered read data, port 2.

## Operation
- Storage: regs[1..31], each XLEN bits. regs[0] does not exist; reads of address 0 return 0.
- Write: at rising edge, if rd_we=1 and rd_addr≠0, regs[rd_addr] ← rd_data. A write with rd_addr=0 is discarded with no side effect.
- Read, when stall=0: at rising edge, rs1_data ← value(rs1_addr) and rs2_data ← value(rs2_addr).
  - value(0) = 0 always, including when rd_we=1 and rd_addr=0 in the same cycle.
  - value(a) for a≠0 = regs[a] as held before the edge, except as modified by RF_BYPASS_EN.
- Read, when stall=1: rs1_data and rs2_data hold. The write port still operates, and writes still update storage.
- Both read ports are independent. Both ports may address the same register.
- Reset (rst_n=0, asynchronous, any time including mid-write): regs[1..31] = 0, rs1_data = 0, rs2_data = 0. A write coincident with reset assertion is lost. The first edge after deassertion behaves normally.

## Timing
- Read latency: 1 cycle. Address presented in cycle N gives data on rs*_data after edge N and valid throughout cycle N+1.
- Write latency: 1 cycle. Storage is updated at edge N and is visible to a read addressed in cycle N+1. Same-cycle visibility depends on RF_BYPASS_EN.
- Stall release: the first edge with stall=0 samples the current addresses and current storage. This includes writes performed during the stall.
- There is no combinational path from any input to any output.

## Configuration
- `RF_BYPASS_EN` defined:
  - A read in the same cycle as a write to the same nonzero address returns rd_data, the new value.
  - Applies per port.
  - Applies to the read sample taken when stall=0.
- `RF_BYPASS_EN` undefined:
  - The same-cycle read returns the old register value.
  - The pipeline must resolve the hazard externally.
  - Storage behaviour is identical in both builds.

## Test plan
- Reset:
  - Stimulus: drive rst_n=0 mid-cycle after writing x5=0x1234_5678, then release and read x5 on both ports.
  - Response: rs1_data=rs2_data=0 immediately on assertion, and x5 reads 0.
- x0 immunity:
  - Stimulus: write rd_addr=0, rd_data=0xDEAD_BEEF, then read rs1_addr=0.
  - Response: rs1_data=0, including a read in the same cycle as the write.
- Basic write/read:
  - Stimulus: write x1=0x0000_0011 and x31=0xFFFF_FFFF on consecutive cycles, then read rs1=1, rs2=31.
  - Response: next cycle rs1_data=0x11, rs2_data=0xFFFF_FFFF.
- Same-cycle hazard:
  - Stimulus: x7 holds 0xA. In one cycle, write x7=0xB and read rs1=7, rs2=7.
  - Response: both ports show 0xB with RF_BYPASS_EN, 0xA without it. A read of x7 in the following cycle returns 0xB in both builds.
- Stall:
  - Stimulus: rs1_data=0x11 (x1). Assert stall for 3 cycles while writing x1=0x22 and changing rs1_addr to 2, then release with rs1_addr=1.
  - Response: rs1_data stays 0x11 during the stall, then 0x22 one cycle after release.
- Random:
  - Stimulus: 10k cycles of random rd_we/addr/data/stall.
  - Response: outputs match a reference model in both RF_BYPASS_EN builds.

Source files
------------

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: RV32I integer register file, 31 storage words plus hardwired x0.
// Two registered read ports (1-cycle latency, freezable by stall), one write port.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   stall                1 = hold rs1_data/rs2_data
//   rs1_addr, rs2_addr   read addresses, sampled on the edge when stall=0
//   rd_we, rd_addr,      write port from the write-back mux
//   rd_data
//   rs1_data, rs2_data   registered read data
//
// Build option: define RF_BYPASS_EN to forward a same-cycle write to the
// read sample (per port). Left undefined, a same-cycle read sees the old value.

module rv32i_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            rd_we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    // x0 has no storage; index 0 is simply absent.
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] rs1_d;
    logic [XLEN-1:0] rs2_d;
    logic            wr_en;

    // Writes to x0 (or beyond NREG) are dropped here, so nothing downstream
    // ever sees them -- including the bypass path.
    assign wr_en = rd_we
                && (rd_addr != 5'd0)
                && (int'(rd_addr) < NREG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_en && (rd_addr == 5'(i))) begin
                    regs_q[i] <= rd_data;
                end
            end
        end
    end

    // Read muxes: default 0 covers x0 and out-of-range addresses.
    always_comb begin
        rs1_d = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs1_addr == 5'(i)) begin
                rs1_d = regs_q[i];
            end
        end
`ifdef RF_BYPASS_EN
        if (wr_en && (rd_addr == rs1_addr)) begin
            rs1_d = rd_data;
        end
`endif
    end

    always_comb begin
        rs2_d = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs2_addr == 5'(i)) begin
                rs2_d = regs_q[i];
            end
        end
`ifdef RF_BYPASS_EN
        if (wr_en && (rd_addr == rs2_addr)) begin
            rs2_d = rd_data;
        end
`endif
    end

    // Output registers hold under stall; storage keeps updating meanwhile,
    // so the first unstalled edge samples post-stall contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (!stall) begin
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
        end
    end

    assign rs1_data = rs1_q;
    assign rs2_data = rs2_q;

endmodule

// File: tb/tb_rv32i_regfile.sv
// tb_rv32i_regfile: directed and randomized checks of rv32i_regfile
// against an array-based reference model.

module tb_rv32i_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];
    logic [31:0] e1;
    logic [31:0] e2;

    always #5 clk = ~clk;

    rv32i_regfile #(.XLEN(32), .NREG(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_we    (rd_we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    function automatic logic [31:0] val(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (rd_we && rd_addr == a) return rd_data;
`endif
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        e1 = 32'd0;
        e2 = 32'd0;
    endtask

    // Advance one edge; model sees the inputs in effect at that edge.
    task automatic cycle();
        if (!stall) begin
            e1 = val(rs1_addr);
            e2 = val(rs2_addr);
        end
        if (rd_we && rd_addr != 5'd0) mem[rd_addr] = rd_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state rs1=%h rs2=%h exp 0", rs1_data, rs2_data);
        end
        rd_we = 1; rd_addr = 5; rd_data = 32'h1234_5678;
        cycle();
        rd_we = 0; rs1_addr = 5; rs2_addr = 5;
        cycle();
        checks++;
        if (rs1_data !== e1 || rs2_data !== e2) begin
            errors++;
            $display("FAIL pre_reset_read rs1=%h rs2=%h exp %h", rs1_data, rs2_data, e1);
        end
        #2;
        rst_n = 0;
        rd_we = 1; rd_addr = 5; rd_data = 32'h0000_FFFF;
        #1;
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_async rs1=%h rs2=%h exp 0", rs1_data, rs2_data);
        end
        @(posedge clk);
        #2;
        rst_n = 1;
        model_reset();
        rd_we = 0;
        cycle();
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_x5 rs1=%h rs2=%h exp 0", rs1_data, rs2_data);
        end
    endtask

    task automatic test_x0();
        rd_we = 1; rd_addr = 3; rd_data = 32'h55;
        cycle();
        rd_we = 0; rs1_addr = 3; rs2_addr = 3;
        cycle();
        checks++;
        if (rs1_data !== 32'h55) begin
            errors++;
            $display("FAIL x0_setup rs1=%h exp 00000055", rs1_data);
        end
        rd_we = 1; rd_addr = 0; rd_data = 32'hDEAD_BEEF;
        rs1_addr = 0; rs2_addr = 0;
        cycle();
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
            errors++;
            $display("FAIL x0_same_cycle rs1=%h rs2=%h exp 0", rs1_data, rs2_data);
        end
        rd_we = 0;
        cycle();
        checks++;
        if (rs1_data !== 32'd0) begin
            errors++;
            $display("FAIL x0_after rs1=%h exp 0", rs1_data);
        end
    endtask

    task automatic test_basic();
        rd_we = 1; rd_addr = 1; rd_data = 32'h11;
        cycle();
        rd_addr = 31; rd_data = 32'hFFFF_FFFF;
        cycle();
        rd_we = 0; rs1_addr = 1; rs2_addr = 31;
        cycle();
        checks++;
        if (rs1_data !== 32'h11 || rs2_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL basic rs1=%h rs2=%h exp 00000011 ffffffff", rs1_data, rs2_data);
        end
    endtask

    task automatic test_hazard();
        logic [31:0] exp_h;
`ifdef RF_BYPASS_EN
        exp_h = 32'hB;
`else
        exp_h = 32'hA;
`endif
        rd_we = 1; rd_addr = 7; rd_data = 32'hA;
        cycle();
        rd_data = 32'hB; rs1_addr = 7; rs2_addr = 7;
        cycle();
        checks++;
        if (rs1_data !== exp_h || rs2_data !== exp_h) begin
            errors++;
            $display("FAIL hazard_same rs1=%h rs2=%h exp %h", rs1_data, rs2_data, exp_h);
        end
        rd_we = 0;
        cycle();
        checks++;
        if (rs1_data !== 32'hB || rs2_data !== 32'hB) begin
            errors++;
            $display("FAIL hazard_next rs1=%h rs2=%h exp 0000000b", rs1_data, rs2_data);
        end
    endtask

    task automatic test_stall();
        rd_we = 0; rs1_addr = 1; rs2_addr = 31;
        cycle();
        checks++;
        if (rs1_data !== 32'h11) begin
            errors++;
            $display("FAIL stall_setup rs1=%h exp 00000011", rs1_data);
        end
        stall = 1; rd_we = 1; rd_addr = 1; rd_data = 32'h22; rs1_addr = 2;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (rs1_data !== 32'h11 || rs2_data !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL stall_hold%0d rs1=%h rs2=%h exp 00000011 ffffffff",
                         k, rs1_data, rs2_data);
            end
        end
        stall = 0; rd_we = 0; rs1_addr = 1;
        cycle();
        checks++;
        if (rs1_data !== 32'h22) begin
            errors++;
            $display("FAIL stall_release rs1=%h exp 00000022", rs1_data);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        for (int n = 0; n < 10000; n++) begin
            stall    = ($urandom_range(0, 3) == 0);
            rd_we    = $urandom_range(0, 1) == 1;
            rd_addr  = 5'($urandom);
            rd_data  = $urandom;
            rs1_addr = 5'($urandom);
            rs2_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
            cycle();
            checks++;
            if (rs1_data !== e1 || rs2_data !== e2) begin
                errors++;
                if (shown < 10) begin
                    $display("FAIL random n=%0d rs1=%h exp %h rs2=%h exp %h",
                             n, rs1_data, e1, rs2_data, e2);
                end
                shown++;
            end
        end
    endtask

    initial begin
        rst_n = 0; stall = 0; rd_we = 0;
        rd_addr = 0; rd_data = 0; rs1_addr = 0; rs2_addr = 0;
        model_reset();
        #23;
        rst_n = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_x0();
        test_basic();
        test_hazard();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
